// File: rtl/mem_pkg.sv
// Shared defaults for the word-addressed memory.
package mem_pkg;

  // Address width in bits; one address selects one full word.
  localparam int MEM_ADDR_W = 18;

  // Word width in bits.
  localparam int MEM_DATA_W = 32;

  // Number of words in the storage array.
  localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

endpackage : mem_pkg

// File: rtl/memory.sv
// Single-port, word-addressed memory with a registered read port.
// A read in the same cycle as a write to the same location returns
// the new data (write-first).
// Reset clears only the read register. The storage array is never
// cleared, so contents loaded through <inst>.data survive reset.
module memory
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH
) (
  output logic [DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0] adress,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              clk,
  input  logic              reset
);

  // Storage array. It has no reset and no initial value; preload it
  // hierarchically through the name data.
  logic [DATA_W-1:0] data [0:DEPTH-1];

  // Array write. Reset is sampled as a level at the clock edge, so a
  // write that coincides with an asserted reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && mem_write) begin
      data[adress] <= write_data;
    end
  end

  // Registered read. Reset forces read_data to zero at once, without
  // waiting for a clock edge. A simultaneous write is forwarded so the
  // read returns the new data. When mem_read is low, read_data holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (mem_read) begin
      if (mem_write) begin
        read_data <= write_data;
      end else begin
        read_data <= data[adress];
      end
    end
  end

endmodule : memory

// File: tb/tb_memory.sv
// Self-checking bench for memory: scoreboard of expected read results
// plus a reference copy of the array contents.
module tb_memory;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int PRELOAD_N = 64;

  logic [DW-1:0] read_data;
  logic [AW-1:0] adress;
  logic [DW-1:0] write_data;
  logic          mem_write;
  logic          mem_read;
  logic          clk;
  logic          reset;

  memory #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .read_data  (read_data),
    .adress     (adress),
    .write_data (write_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .clk        (clk),
    .reset      (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mdl [int];  // reference array contents
  logic [DW-1:0] sb  [$];    // expected read results, oldest first
  logic [DW-1:0] m_rd;       // reference copy of read_data

  // One bus cycle. Inputs change on the falling edge. The expected read
  // value is pushed when the request is driven. The reference model is
  // updated after the rising edge.
  task automatic cycle(input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] exp;
    @(negedge clk);
    mem_write  = we;
    mem_read   = re;
    adress     = a;
    write_data = wd;
    if (re) begin
      exp = we ? wd : mdl[int'(a)];
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    if (we) mdl[int'(a)] = wd;
    if (re) m_rd = sb[$];
  endtask

  task automatic idle();
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    reset = 1'b1;
    mem_write = 1'b0;
    mem_read = 1'b0;
    adress = '0;
    write_data = '0;
    #2;
    checks++;
    if (read_data !== '0) begin
      errors++;
      $display("FAIL reset_value: read_data=%h expected=%h", read_data, 32'h0);
    end
    // Preload the array while reset is still held.
    for (int i = 0; i < PRELOAD_N; i++) begin
      v = (i == 4) ? 32'h0000_0001 : $urandom;
      dut.data[i] = v;
      mdl[i] = v;
    end
    @(negedge clk);
    reset = 1'b0;
    m_rd = '0;
  endtask

  task automatic test_preload_read();
    logic [DW-1:0] exp;
    cycle(1'b0, 1'b1, 18'd4, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== exp || exp !== 32'h0000_0001) begin
      errors++;
      $display("FAIL preload_read4: read_data=%h expected=%h", read_data, 32'h0000_0001);
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp;
    cycle(1'b1, 1'b0, 18'd4, 32'h0000_000F);
    checks++;
    if (read_data !== m_rd) begin
      errors++;
      $display("FAIL write_no_read_hold: read_data=%h expected=%h", read_data, m_rd);
    end
    cycle(1'b0, 1'b1, 18'd4, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== 32'h0000_000F || exp !== 32'h0000_000F) begin
      errors++;
      $display("FAIL write_then_read4: read_data=%h expected=%h", read_data, 32'h0000_000F);
    end
    idle();
  endtask

  task automatic test_sequential_reads();
    logic [DW-1:0] exp;
    cycle(1'b0, 1'b1, 18'd8, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++;
      $display("FAIL seq_read8: read_data=%h expected=%h", read_data, exp);
    end
    cycle(1'b0, 1'b1, 18'd12, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++;
      $display("FAIL seq_read12: read_data=%h expected=%h", read_data, exp);
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] exp;
    // Assert reset between clock edges, with a write pending.
    @(negedge clk);
    #2;
    mem_write  = 1'b1;
    mem_read   = 1'b1;
    adress     = 18'd4;
    write_data = 32'hDEAD_BEEF;
    reset      = 1'b1;
    #1;
    checks++;
    if (read_data !== '0) begin
      errors++;
      $display("FAIL async_reset_immediate: read_data=%h expected=%h", read_data, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (read_data !== '0) begin
      errors++;
      $display("FAIL reset_edge_read: read_data=%h expected=%h", read_data, 32'h0);
    end
    #2;
    reset     = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    m_rd      = '0;
    cycle(1'b0, 1'b1, 18'd4, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== 32'h0000_000F || exp !== 32'h0000_000F) begin
      errors++;
      $display("FAIL read4_after_reset: read_data=%h expected=%h", read_data, 32'h0000_000F);
    end
    idle();
  endtask

  task automatic test_write_first();
    logic [DW-1:0] exp;
    cycle(1'b1, 1'b1, 18'd4, 32'hA5A5_A5A5);
    exp = sb.pop_front();
    checks++;
    if (read_data !== 32'hA5A5_A5A5 || exp !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL write_first4: read_data=%h expected=%h", read_data, 32'hA5A5_A5A5);
    end
    cycle(1'b0, 1'b1, 18'd4, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++;
      $display("FAIL write_first_readback: read_data=%h expected=%h", read_data, exp);
    end
    idle();
  endtask

  task automatic test_hold();
    logic [DW-1:0] exp;
    cycle(1'b0, 1'b1, 18'd20, '0);
    exp = sb.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++;
      $display("FAIL hold_setup_read20: read_data=%h expected=%h", read_data, exp);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, AW'(i * 7 + 1), $urandom);
      checks++;
      if (read_data !== m_rd) begin
        errors++;
        $display("FAIL hold_no_read%0d: read_data=%h expected=%h", i, read_data, m_rd);
      end
    end
    // A write without a read must also leave read_data unchanged.
    cycle(1'b1, 1'b0, 18'd20, 32'h1234_5678);
    checks++;
    if (read_data !== m_rd) begin
      errors++;
      $display("FAIL hold_write_only: read_data=%h expected=%h", read_data, m_rd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    logic we, re;
    logic [AW-1:0] a;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, PRELOAD_N - 1));
      cycle(we, re, a, $urandom);
      if (re) begin
        exp = sb.pop_front();
        checks++;
        if (read_data !== exp) begin
          errors++;
          $display("FAIL b2b_read%0d addr=%0d: read_data=%h expected=%h", i, a, read_data, exp);
        end
      end else begin
        checks++;
        if (read_data !== m_rd) begin
          errors++;
          $display("FAIL b2b_hold%0d: read_data=%h expected=%h", i, read_data, m_rd);
        end
      end
    end
    idle();
  endtask

  task automatic test_array_contents();
    for (int i = 0; i < PRELOAD_N; i++) begin
      checks++;
      if (dut.data[i] !== mdl[i]) begin
        errors++;
        $display("FAIL array_word%0d: data=%h expected=%h", i, dut.data[i], mdl[i]);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_sequential_reads();
    test_async_reset();
    test_write_first();
    test_hold();
    test_back_to_back();
    test_array_contents();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_memory
